// File: rtl/montre_de1_sysid_check_if.sv
// Avalon-MM read-only link between the sysid check sequencer and the system-ID slave.
`default_nettype none

interface montre_de1_sysid_check_if;
  logic        sid_address;
  logic        sid_read;
  logic [31:0] sid_readdata;

  modport master (output sid_address, output sid_read, input sid_readdata);
  modport slave  (input sid_address, input sid_read, output sid_readdata);
endinterface

`default_nettype wire

// File: rtl/montre_de1_sysid_check.sv
// Boot-time system-ID check: reads ID and timestamp words, compares them to build-time values,
// retries on mismatch and publishes a sticky pass/fail result. Rev 1.0
`default_nettype none

module montre_de1_sysid_check #(
  parameter logic [31:0] EXPECTED_ID  = 32'd0,
  parameter logic [31:0] EXPECTED_TS  = 32'd1684023273,
  parameter int          READ_LATENCY = 0,
  parameter int          RETRY_MAX    = 3,
  parameter bit          AUTO_START   = 1'b1
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          start,
  montre_de1_sysid_check_if.master      sid,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic                          id_ok,
  output logic                          ts_ok,
  output logic [31:0]                   id_value,
  output logic [31:0]                   ts_value,
  output logic [2:0]                    retries
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_ID   = 3'd1;
  localparam logic [2:0] S_WAIT_ID = 3'd2;
  localparam logic [2:0] S_RD_TS   = 3'd3;
  localparam logic [2:0] S_WAIT_TS = 3'd4;
  localparam logic [2:0] S_CHECK   = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam bit         HAS_WAIT    = (READ_LATENCY > 0);
  localparam logic [1:0] LAST_WAIT   = HAS_WAIT ? 2'(READ_LATENCY - 1) : 2'd0;
  localparam logic [2:0] RETRY_LIMIT = 3'(RETRY_MAX);

  logic [2:0] state;
  logic [2:0] state_next;
  logic [1:0] wait_cnt;
  logic [2:0] retry_cnt;
  logic       auto_pending;
  logic       addr_hold;
  logic       launch;
  logic       wait_last;
  logic       cap_id;
  logic       cap_ts;
  logic       id_match;
  logic       ts_match;
  logic       give_up;

  // auto_pending is armed by reset so the first IDLE cycle after release launches a check
  assign launch    = start | auto_pending;
  assign wait_last = (wait_cnt == LAST_WAIT);
  assign cap_id    = HAS_WAIT ? (state == S_WAIT_ID && wait_last) : (state == S_RD_ID);
  assign cap_ts    = HAS_WAIT ? (state == S_WAIT_TS && wait_last) : (state == S_RD_TS);
  assign id_match  = (id_value == EXPECTED_ID);
  assign ts_match  = (ts_value == EXPECTED_TS);
  assign give_up   = (id_match & ts_match) | (retry_cnt == RETRY_LIMIT);

  always_ff @(posedge clock) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (launch) state_next = S_RD_ID;
      S_RD_ID:   state_next = HAS_WAIT ? S_WAIT_ID : S_RD_TS;
      S_WAIT_ID: if (wait_last) state_next = S_RD_TS;
      S_RD_TS:   state_next = HAS_WAIT ? S_WAIT_TS : S_CHECK;
      S_WAIT_TS: if (wait_last) state_next = S_CHECK;
      S_CHECK:   state_next = give_up ? S_DONE : S_RD_ID;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    sid.sid_read    = (state == S_RD_ID) || (state == S_RD_TS);
    sid.sid_address = addr_hold;
    if (state == S_RD_ID)      sid.sid_address = 1'b0;
    else if (state == S_RD_TS) sid.sid_address = 1'b1;
    busy = (state != S_IDLE) && (state != S_DONE);
    done = (state == S_DONE);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      auto_pending <= AUTO_START;
      addr_hold    <= 1'b0;
      wait_cnt     <= 2'd0;
      retry_cnt    <= 3'd0;
      pass         <= 1'b0;
      id_ok        <= 1'b0;
      ts_ok        <= 1'b0;
      id_value     <= 32'd0;
      ts_value     <= 32'd0;
      retries      <= 3'd0;
    end else begin
      if (state == S_IDLE && launch) begin
        auto_pending <= 1'b0;
        pass         <= 1'b0;
        id_ok        <= 1'b0;
        ts_ok        <= 1'b0;
        retry_cnt    <= 3'd0;
      end
      if (state == S_RD_ID) addr_hold <= 1'b0;
      if (state == S_RD_TS) addr_hold <= 1'b1;
      if (state == S_WAIT_ID || state == S_WAIT_TS)
        wait_cnt <= wait_last ? 2'd0 : wait_cnt + 2'd1;
      else
        wait_cnt <= 2'd0;
      if (cap_id) id_value <= sid.sid_readdata;
      if (cap_ts) ts_value <= sid.sid_readdata;
      // result registers settle on entry to DONE so they are valid alongside the done pulse
      if (state == S_CHECK) begin
        id_ok <= id_match;
        ts_ok <= ts_match;
        if (give_up) begin
          pass    <= id_match & ts_match;
          retries <= retry_cnt;
        end else begin
          retry_cnt <= retry_cnt + 3'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_montre_de1_sysid_check.sv
// Bench for montre_de1_sysid_check: four parameterisations side by side plus a randomized retry model.
`timescale 1ns/1ps
`default_nettype none

module tb_montre_de1_sysid_check;
  localparam logic [31:0] TS = 32'd1684023273;
  localparam logic [31:0] ID = 32'd0;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [3:0]  rstn;
  logic [3:0]  start;
  logic [3:0]  busy, done, pass, idok, tsok;
  logic [31:0] idv [4];
  logic [31:0] tsv [4];
  logic [2:0]  rtr [4];

  montre_de1_sysid_check_if if0 ();
  montre_de1_sysid_check_if if1 ();
  montre_de1_sysid_check_if if2 ();
  montre_de1_sysid_check_if if3 ();

  wire [3:0] rd = {if3.sid_read, if2.sid_read, if1.sid_read, if0.sid_read};

  montre_de1_sysid_check u0 (
    .clock(clock), .reset_n(rstn[0]), .start(start[0]), .sid(if0),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .id_ok(idok[0]), .ts_ok(tsok[0]),
    .id_value(idv[0]), .ts_value(tsv[0]), .retries(rtr[0]));
  montre_de1_sysid_check #(.EXPECTED_TS(32'd0), .RETRY_MAX(2)) u1 (
    .clock(clock), .reset_n(rstn[1]), .start(start[1]), .sid(if1),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .id_ok(idok[1]), .ts_ok(tsok[1]),
    .id_value(idv[1]), .ts_value(tsv[1]), .retries(rtr[1]));
  montre_de1_sysid_check #(.READ_LATENCY(2)) u2 (
    .clock(clock), .reset_n(rstn[2]), .start(start[2]), .sid(if2),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .id_ok(idok[2]), .ts_ok(tsok[2]),
    .id_value(idv[2]), .ts_value(tsv[2]), .retries(rtr[2]));
  montre_de1_sysid_check #(.AUTO_START(1'b0)) u3 (
    .clock(clock), .reset_n(rstn[3]), .start(start[3]), .sid(if3),
    .busy(busy[3]), .done(done[3]), .pass(pass[3]), .id_ok(idok[3]), .ts_ok(tsok[3]),
    .id_value(idv[3]), .ts_value(tsv[3]), .retries(rtr[3]));

  // u0 slave: per-attempt planned words, attempt index advances on each timestamp read
  logic [31:0] id_plan [4];
  logic [31:0] ts_plan [4];
  int unsigned k0 = 0;
  int unsigned k0_base;
  int unsigned idx0;
  always @(posedge clock) if (if0.sid_read && if0.sid_address) k0 <= k0 + 1;
  always_comb begin
    idx0 = k0 - k0_base;
    if (idx0 < 4) if0.sid_readdata = if0.sid_address ? ts_plan[idx0[1:0]] : id_plan[idx0[1:0]];
    else          if0.sid_readdata = if0.sid_address ? TS : ID;
  end

  assign if1.sid_readdata = if1.sid_address ? TS : ID;
  assign if3.sid_readdata = if3.sid_address ? TS : ID;

  // u2 slave: data valid only two cycles after the read, garbage otherwise
  logic [1:0] rd_pipe = 2'b00;
  logic [1:0] ad_pipe = 2'b00;
  always @(posedge clock) begin
    rd_pipe <= {rd_pipe[0], if2.sid_read};
    ad_pipe <= {ad_pipe[0], if2.sid_address};
  end
  assign if2.sid_readdata = rd_pipe[1] ? (ad_pipe[1] ? TS : ID) : 32'hDEAD_BEEF;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic plan_good();
    for (int a = 0; a < 4; a++) begin
      id_plan[a] = ID;
      ts_plan[a] = TS;
    end
    k0_base = k0;
  endtask

  int donecnt [4];
  int donecyc [4];
  logic        pass_at [4];
  logic        idok_at [4];
  logic        tsok_at [4];
  logic [31:0] idv_at  [4];
  logic [31:0] tsv_at  [4];
  logic [2:0]  rtr_at  [4];
  int   rdq_cyc [$];
  logic rdq_ad  [$];
  int   rd1_cnt, u3_act, dq [$], rcnt, got, r_exp;
  logic [1:0]  mode;
  logic        good;

  initial begin
    rstn = 4'b0000;
    start = 4'b0000;
    plan_good();
    for (int i = 0; i < 4; i++) begin
      donecnt[i] = 0; donecyc[i] = -1;
      pass_at[i] = 1'bx; idok_at[i] = 1'bx; tsok_at[i] = 1'bx;
      idv_at[i] = 'x; tsv_at[i] = 'x; rtr_at[i] = 'x;
    end
    repeat (3) tick();

    // reset state on every instance
    chk("reset_read", {28'd0, rd}, 32'd0);
    chk("reset_busy", {28'd0, busy}, 32'd0);
    chk("reset_done", {28'd0, done}, 32'd0);
    chk("reset_pass", {28'd0, pass | idok | tsok}, 32'd0);
    chk("reset_values", idv[0] | tsv[0] | idv[2] | tsv[2] | 32'(rtr[0]), 32'd0);

    // cycle 0 is the first cycle with reset released
    rstn = 4'b1111;
    rd1_cnt = 0; u3_act = 0;
    for (int cyc = 0; cyc < 120; cyc++) begin
      if (rd[0]) begin rdq_cyc.push_back(cyc); rdq_ad.push_back(if0.sid_address); end
      if (rd[1]) rd1_cnt++;
      if (rd[3] || busy[3] || done[3] || pass[3]) u3_act++;
      for (int i = 0; i < 4; i++) if (done[i]) begin
        donecnt[i]++;
        if (donecnt[i] == 1) begin
          donecyc[i] = cyc; pass_at[i] = pass[i]; idok_at[i] = idok[i]; tsok_at[i] = tsok[i];
          idv_at[i] = idv[i]; tsv_at[i] = tsv[i]; rtr_at[i] = rtr[i];
        end
      end
      tick();
    end

    chk("t1_read_count", rdq_cyc.size(), 2);
    if (rdq_cyc.size() == 2) begin
      chk("t1_rd_id_cycle", rdq_cyc[0], 1);
      chk("t1_rd_id_addr", {31'd0, rdq_ad[0]}, 0);
      chk("t1_rd_ts_cycle", rdq_cyc[1], 2);
      chk("t1_rd_ts_addr", {31'd0, rdq_ad[1]}, 1);
    end
    chk("t1_done_count", donecnt[0], 1);
    chk("t1_done_cycle", donecyc[0], 4);
    chk("t1_pass", {31'd0, pass_at[0]}, 1);
    chk("t1_id_value", idv_at[0], ID);
    chk("t1_ts_value", tsv_at[0], TS);
    chk("t1_retries", {29'd0, rtr_at[0]}, 0);

    chk("t2_done_count", donecnt[1], 1);
    chk("t2_done_cycle", donecyc[1], 10);
    chk("t2_reads", rd1_cnt, 6);
    chk("t2_pass", {31'd0, pass_at[1]}, 0);
    chk("t2_id_ok", {31'd0, idok_at[1]}, 1);
    chk("t2_ts_ok", {31'd0, tsok_at[1]}, 0);
    chk("t2_retries", {29'd0, rtr_at[1]}, 2);

    chk("t3_auto_done_cycle", donecyc[2], 8);
    chk("t3_auto_pass", {31'd0, pass_at[2]}, 1);
    chk("t3_auto_ts_value", tsv_at[2], TS);

    chk("t6_activity", u3_act, 0);

    // latency-2 instance, explicit start pulse
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    got = -1;
    for (int c = 1; c <= 20; c++) begin
      if (done[2] && got < 0) begin got = c; pass_at[2] = pass[2]; end
      tick();
    end
    chk("t3_start_to_done", got, 8);
    chk("t3_pass", {31'd0, pass_at[2]}, 1);

    // start held through the whole check and the following IDLE cycle
    plan_good();
    dq.delete(); rcnt = 0;
    for (int c = 0; c < 16; c++) begin
      start[0] = (c <= 5);
      if (done[0]) dq.push_back(c);
      if (rd[0]) rcnt++;
      tick();
    end
    start[0] = 1'b0;
    chk("t4_done_count", dq.size(), 2);
    if (dq.size() == 2) begin
      chk("t4_first_done", dq[0], 4);
      chk("t4_second_done", dq[1], 9);
    end
    chk("t4_reads", rcnt, 4);

    // randomized attempt plans against a first-good-attempt model
    for (int it = 0; it < 20; it++) begin
      r_exp = 3;
      for (int a = 3; a >= 0; a--) begin
        mode = 2'($urandom_range(0, 3));
        id_plan[a] = mode[0] ? (ID ^ ($urandom | 32'd1)) : ID;
        ts_plan[a] = mode[1] ? (TS ^ ($urandom | 32'd1)) : TS;
        if (mode == 2'd0) r_exp = a;
      end
      k0_base = k0;
      good = (id_plan[r_exp] == ID) && (ts_plan[r_exp] == TS);
      start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      got = -1;
      for (int c = 1; c <= 30; c++) begin
        if (done[0] && got < 0) begin
          got = c; pass_at[0] = pass[0]; idok_at[0] = idok[0]; tsok_at[0] = tsok[0];
          idv_at[0] = idv[0]; tsv_at[0] = tsv[0]; rtr_at[0] = rtr[0];
        end
        tick();
      end
      chk("rand_done_cycle", got, 4 + 3 * r_exp);
      chk("rand_pass", {31'd0, pass_at[0]}, {31'd0, good});
      chk("rand_id_ok", {31'd0, idok_at[0]}, {31'd0, id_plan[r_exp] == ID});
      chk("rand_ts_ok", {31'd0, tsok_at[0]}, {31'd0, ts_plan[r_exp] == TS});
      chk("rand_id_value", idv_at[0], id_plan[r_exp]);
      chk("rand_ts_value", tsv_at[0], ts_plan[r_exp]);
      chk("rand_retries", {29'd0, rtr_at[0]}, r_exp);
    end

    // reset asserted during the timestamp read
    plan_good();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    tick();
    chk("t5_in_rd_ts", {30'd0, rd[0], if0.sid_address}, 32'd3);
    rstn[0] = 1'b0;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    chk("t5_read_low", {31'd0, rd[0]}, 0);
    chk("t5_busy_done", {30'd0, busy[0], done[0]}, 0);
    chk("t5_flags", {29'd0, pass[0], idok[0], tsok[0]}, 0);
    chk("t5_values", idv[0] | tsv[0] | 32'(rtr[0]), 0);
    rstn[0] = 1'b1;
    plan_good();
    dq.delete();
    for (int c = 0; c < 12; c++) begin
      if (done[0]) begin dq.push_back(c); pass_at[0] = pass[0]; end
      tick();
    end
    chk("t5_restart_dones", dq.size(), 1);
    if (dq.size() == 1) chk("t5_restart_cycle", dq[0], 4);
    chk("t5_restart_pass", {31'd0, pass_at[0]}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bench timeout");
  end

endmodule

`default_nettype wire
